// File: rtl/hazard_pkg.sv
// hazard_pkg: stall reason encodings, default mult/div latency and register-match helper
package hazard_pkg;
  typedef enum logic [1:0] {
    NONE       = 2'd0,
    LOAD_USE   = 2'd1,
    BRANCH_DEP = 2'd2,
    MULDIV     = 2'd3
  } stallReasonT;
  localparam int MULDIV_CYCLES_DEF = 32;
  // register $0 is hardwired to zero, so it can never create a dependency
  function automatic logic regMatch(input logic [4:0] r, input logic [4:0] rs, input logic [4:0] rt,
                                    input logic usesRs, input logic usesRt);
    return (r != 5'd0) && ((usesRs && r == rs) || (usesRt && r == rt));
  endfunction
endpackage

// File: rtl/muldiv_busy_counter.sv
// muldiv_busy_counter: tracks remaining busy cycles of the multi-cycle mult/div unit
module muldiv_busy_counter #(
  parameter int MULDIV_CYCLES = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done
);
  localparam int W = $clog2(MULDIV_CYCLES + 1);
  logic [W-1:0] cnt;
  // a start only loads when idle; a start while busy is ignored
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (start && cnt == '0) cnt <= W'(MULDIV_CYCLES);
    else if (cnt != '0) cnt <= cnt - W'(1);
  assign busy = cnt != '0;
  assign done = cnt == W'(1);
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / branch-operand / mult-div hazard detection with stall and flush control
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULDIV_CYCLES = MULDIV_CYCLES_DEF,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_is_branch,
  input  logic             id_is_hilo,
  input  logic             id_take,
  input  logic [4:0]       ex_wreg,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [4:0]       mem_wreg,
  input  logic             mem_mem_read,
  input  logic             ex_muldiv_start,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       stall_reason,
  output logic             muldiv_busy,
  output logic             muldiv_done,
  output logic [CNT_W-1:0] stall_cycles
);
  logic exMatch, memMatch, loadUse, branchDep, mdHold, stall;
  stallReasonT reason;
  muldiv_busy_counter #(.MULDIV_CYCLES(MULDIV_CYCLES)) uCounter (
    .clk  (clk),
    .reset(reset),
    .start(ex_muldiv_start),
    .busy (muldiv_busy),
    .done (muldiv_done)
  );
  assign exMatch   = regMatch(ex_wreg, id_rs, id_rt, id_uses_rs, id_uses_rt);
  assign memMatch  = regMatch(mem_wreg, id_rs, id_rt, id_uses_rs, id_uses_rt);
  assign loadUse   = ex_mem_read && ex_reg_write && exMatch;
  assign branchDep = id_is_branch && ((ex_reg_write && exMatch) || (mem_mem_read && memMatch));
  assign mdHold    = id_is_hilo && muldiv_busy;
  // priority select of the stall cause; reset forces NONE
  always_comb begin
    reason = reset ? NONE : loadUse ? LOAD_USE : branchDep ? BRANCH_DEP : mdHold ? MULDIV : NONE;
    stall  = reason != NONE;
  end
  assign stall_reason = reason;
  assign pc_write     = !reset && !stall;
  assign ifid_write   = !reset && !stall;
  assign idex_flush   = reset || stall;
  assign ifid_flush   = reset || (!stall && id_take);
  // performance counter of stalled cycles, wraps naturally
  always_ff @(posedge clk or posedge reset)
    if (reset) stall_cycles <= '0;
    else if (stall) stall_cycles <= stall_cycles + CNT_W'(1);
endmodule
